// File: rtl/dram_refresh_ctrl_pkg.sv
// Shared types and default timing constants for the DRAM refresh scheduler.
package dram_refresh_ctrl_pkg;

    localparam int unsigned tREFIc           = 6240;
    localparam int unsigned tRFCc            = 280;
    localparam int unsigned REF_MAX_POSTPONE = 8;
    localparam int unsigned DEBT_W           = 4;

    typedef enum logic [1:0] {
        IDLE,
        FORCE,
        ISSUE,
        TRFC
    } refresh_state_t;

endpackage

// File: rtl/refresh_interval_timer.sv
// Free-running wrap counter that pulses tick_c_o for one cycle every PERIOD enabled cycles.
module refresh_interval_timer
    import dram_refresh_ctrl_pkg::*;
#(
    parameter int unsigned PERIOD = tREFIc,
    parameter int unsigned CNT_W  = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_c_o
);

    logic [CNT_W-1:0] cnt_q;

    assign tick_c_o = en_i && (cnt_q == CNT_W'(PERIOD - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (tick_c_o) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dram_refresh_ctrl.sv
// Refresh scheduler: accumulates tREFI debt, issues REF opportunistically or by force,
// and blocks new traffic for tRFC after each REF.
module dram_refresh_ctrl
    import dram_refresh_ctrl_pkg::*;
#(
    parameter int unsigned TREFI_CYC    = tREFIc,
    parameter int unsigned TRFC_CYC     = tRFCc,
    parameter int unsigned MAX_POSTPONE = REF_MAX_POSTPONE,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              init_done,
    input  logic              req_pending,
    input  logic              busy,
    input  logic              refresh_ack,
    output logic              REFRESH,
    output logic              block_sched,
    output logic [DEBT_W-1:0] debt,
    output logic              refresh_err
);

    localparam logic [DEBT_W-1:0] DEBT_MAX = DEBT_W'(MAX_POSTPONE);

    refresh_state_t    state_q;
    logic [CNT_W-1:0]  trfc_cnt_q;
    logic [DEBT_W-1:0] debt_q, debt_d;
    logic              err_q, err_d;
    logic              refresh_q;
    logic              block_q;
    logic              tick_c;
    logic              ack_acc_c;

    refresh_interval_timer #(
        .PERIOD (TREFI_CYC),
        .CNT_W  (CNT_W)
    ) u_trefi_timer (
        .clk_i    (CLK),
        .rst_i    (RST),
        .en_i     (init_done),
        .tick_c_o (tick_c)
    );

    // An ack with no outstanding debt is meaningless and is dropped.
    assign ack_acc_c = refresh_ack && (debt_q != '0);

    always_comb begin
        debt_d = debt_q;
        err_d  = err_q;
        if (tick_c && !ack_acc_c) begin
            if (debt_q == DEBT_MAX) begin
                err_d = 1'b1;
            end else begin
                debt_d = debt_q + DEBT_W'(1);
            end
        end else if (ack_acc_c && !tick_c) begin
            debt_d = debt_q - DEBT_W'(1);
        end
    end

    // FSM with outputs registered alongside the state they belong to.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            trfc_cnt_q <= '0;
            debt_q     <= '0;
            err_q      <= 1'b0;
            refresh_q  <= 1'b0;
            block_q    <= 1'b0;
        end else begin
            debt_q <= debt_d;
            err_q  <= err_d;
            case (state_q)
                IDLE: begin
                    if (debt_q == DEBT_MAX) begin
                        state_q <= FORCE;
                        block_q <= 1'b1;
                    end else if ((debt_q != '0) && !req_pending && !busy) begin
                        state_q   <= ISSUE;
                        refresh_q <= 1'b1;
                        block_q   <= 1'b1;
                    end
                end
                FORCE: begin
                    if (!busy) begin
                        state_q   <= ISSUE;
                        refresh_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (refresh_ack) begin
                        state_q    <= TRFC;
                        refresh_q  <= 1'b0;
                        trfc_cnt_q <= CNT_W'(TRFC_CYC - 1);
                    end
                end
                TRFC: begin
                    if (trfc_cnt_q == '0) begin
                        state_q <= IDLE;
                        block_q <= 1'b0;
                    end else begin
                        trfc_cnt_q <= trfc_cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    refresh_q <= 1'b0;
                    block_q   <= 1'b0;
                end
            endcase
        end
    end

    assign REFRESH     = refresh_q;
    assign block_sched = block_q;
    assign debt        = debt_q;
    assign refresh_err = err_q;

endmodule

// File: tb/tb_dram_refresh_ctrl.sv
// Randomized scoreboard bench for dram_refresh_ctrl against a phase-level reference model.
module tb_dram_refresh_ctrl;

    localparam int TREFI = 20;
    localparam int TRFC  = 5;
    localparam int MAXP  = 8;

    localparam int PH_IDLE  = 0;
    localparam int PH_FORCE = 1;
    localparam int PH_ISSUE = 2;
    localparam int PH_TRFC  = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       init_done = 1'b0;
    logic       req_pending = 1'b0;
    logic       busy = 1'b0;
    logic       refresh_ack = 1'b0;
    logic       REFRESH;
    logic       block_sched;
    logic [3:0] debt;
    logic       refresh_err;

    typedef struct {
        bit refresh;
        bit block;
        int debt;
        bit err;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: elapsed enabled cycles, outstanding debt, and the refresh phase.
    int m_elapsed = 0;
    int m_debt    = 0;
    bit m_err     = 0;
    int m_phase   = PH_IDLE;
    int m_left    = 0;
    int m_age     = 0;

    dram_refresh_ctrl #(
        .TREFI_CYC    (TREFI),
        .TRFC_CYC     (TRFC),
        .MAX_POSTPONE (MAXP),
        .CNT_W        (16)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .init_done   (init_done),
        .req_pending (req_pending),
        .busy        (busy),
        .refresh_ack (refresh_ack),
        .REFRESH     (REFRESH),
        .block_sched (block_sched),
        .debt        (debt),
        .refresh_err (refresh_err)
    );

    always #5 CLK = ~CLK;

    function automatic bit tick_next(input bit init);
        return init && ((m_elapsed % TREFI) == TREFI - 1);
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input bit rst, input bit init, input bit req, input bit bsy, input bit ack);
        bit tick;
        bit acc;
        int nd;
        exp_t e;
        @(negedge CLK);
        RST = rst; init_done = init; req_pending = req; busy = bsy; refresh_ack = ack;
        if (rst) begin
            m_elapsed = 0; m_debt = 0; m_err = 0;
            m_phase = PH_IDLE; m_left = 0; m_age = 0;
        end else begin
            assert (!(ack && m_debt == 0)) else $error("refresh_ack driven with zero debt");
            tick = tick_next(init);
            if (init) m_elapsed++;
            acc = ack && (m_debt > 0);
            nd = m_debt + int'(tick) - int'(acc);
            if (nd > MAXP) begin
                nd = MAXP;
                m_err = 1;
            end
            case (m_phase)
                PH_IDLE: begin
                    if (m_debt == MAXP) m_phase = PH_FORCE;
                    else if (m_debt > 0 && !req && !bsy) begin m_phase = PH_ISSUE; m_age = 0; end
                end
                PH_FORCE: if (!bsy) begin m_phase = PH_ISSUE; m_age = 0; end
                PH_ISSUE: begin
                    if (ack) begin m_phase = PH_TRFC; m_left = TRFC; end
                    else m_age++;
                end
                default: begin
                    m_left--;
                    if (m_left == 0) m_phase = PH_IDLE;
                end
            endcase
            m_debt = nd;
        end
        e.refresh = (m_phase == PH_ISSUE);
        e.block   = (m_phase != PH_IDLE);
        e.debt    = m_debt;
        e.err     = m_err;
        exp_q.push_back(e);
    endtask

    // ack_dly >= 0: ack after that many REFRESH cycles; ack_dly < 0: ack only on a tick cycle.
    task automatic cyc(input bit init, input bit req, input bit bsy, input int ack_dly);
        bit ack;
        if (ack_dly < 0) ack = (m_phase == PH_ISSUE) && tick_next(init);
        else             ack = (m_phase == PH_ISSUE) && (m_age >= ack_dly);
        step(1'b0, init, req, bsy, ack);
    endtask

    task automatic timeout_fail(input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL timeout %s: condition not reached, debt model=%0d phase=%0d", what, m_debt, m_phase);
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("REFRESH",     int'(REFRESH),     int'(e.refresh));
                chk("block_sched", int'(block_sched), int'(e.block));
                chk("debt",        int'(debt),        e.debt);
                chk("refresh_err", int'(refresh_err), int'(e.err));
            end
        end
    end

    initial begin : driver
        int k;
        // Reset, then a long init window with no ticks.
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (100) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Opportunistic refresh with ack three cycles after REFRESH.
        repeat (60) cyc(1'b1, 1'b0, 1'b0, 3);

        // Postpone up to the limit, force while busy, then release.
        k = 0;
        while (m_debt < MAXP && k < 400) begin cyc(1'b1, 1'b1, 1'b0, 3); k++; end
        if (k >= 400) timeout_fail("postpone");
        repeat (10) cyc(1'b1, 1'b1, 1'b1, 3);
        repeat (15) cyc(1'b1, 1'b1, 1'b0, 3);

        // Overflow: hold busy through the next tick at full debt.
        k = 0;
        while (m_debt < MAXP && k < 400) begin cyc(1'b1, 1'b1, 1'b1, 3); k++; end
        if (k >= 400) timeout_fail("overflow fill");
        repeat (25) cyc(1'b1, 1'b1, 1'b1, 3);
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 3);

        // Ack coincident with a tick at debt 3.
        k = 0;
        while (m_debt < 3 && k < 200) begin cyc(1'b1, 1'b1, 1'b0, 3); k++; end
        if (k >= 200) timeout_fail("debt 3");
        k = 0;
        while (m_phase != PH_TRFC && k < 80) begin cyc(1'b1, 1'b0, 1'b0, -1); k++; end
        if (k >= 80) timeout_fail("ack on tick");
        repeat (8) cyc(1'b1, 1'b1, 1'b0, 3);

        // Reset while in tRFC with two cycles remaining.
        k = 0;
        while (!(m_phase == PH_TRFC && m_left == 2) && k < 200) begin cyc(1'b1, 1'b0, 1'b0, 2); k++; end
        if (k >= 200) timeout_fail("trfc mid");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) cyc(1'b1, 1'b1, 1'b0, 2);

        // Randomized traffic in episodes of varying request density.
        for (int ep = 0; ep < 20; ep++) begin
            int req_pct;
            int busy_pct;
            req_pct  = $urandom_range(0, 100);
            busy_pct = $urandom_range(0, 60);
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 599) == 0) begin
                    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                end else begin
                    cyc($urandom_range(0, 19) != 0,
                        $urandom_range(0, 99) < req_pct,
                        $urandom_range(0, 99) < busy_pct,
                        $urandom_range(0, 4));
                end
            end
        end

        repeat (3) @(posedge CLK);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dram_refresh_ctrl.md
Name: dram_refresh_ctrl

Overview:
Refresh scheduler sitting directly upstream of dram_command. It drives the REFRESH request input of dram_command. It tracks tREFI elapsed time and accumulates refresh debt, up to the DDR4 limit of 8 postponed refreshes. It issues refreshes opportunistically when the scheduler is idle, or forces them by stalling the scheduler_buffer when debt reaches the limit. After each refresh it holds off all traffic for tRFC.

Parameters:
TREFI_CYC, 6240, tREFI in CLK cycles (7.8 us at 1.25 ns).
TRFC_CYC, 280, tRFC in CLK cycles (350 ns, 8 Gb device).
MAX_POSTPONE, 8, maximum outstanding refresh debt before a refresh is forced.
CNT_W, 16, width of the interval and tRFC counters; must satisfy 2^CNT_W > max(TREFI_CYC, TRFC_CYC).

Ports:
CLK  in  1  system clock, the same clock as dram_command.
RST  in  1  synchronous, active-high reset.
init_done  in  1  power-up/ZQ init sequence complete; the interval counter is frozen while low.
req_pending  in  1  scheduler_buffer holds at least one valid request (curr or ftrt).
busy  in  1  dram_command is mid-access (ACT..PRE window not closed); a REF must not be issued.
refresh_ack  in  1  one-cycle pulse from dram_command when the REF command is driven onto the bus.
REFRESH  out  1  level request to dram_command (dc_if.REFRESH); held until refresh_ack.
block_sched  out  1  stalls scheduler_buffer from launching new requests.
debt  out  4  current outstanding refresh count, 0..MAX_POSTPONE.
refresh_err  out  1  sticky flag: a tREFI tick arrived while debt==MAX_POSTPONE.

Behaviour:
- Reset: on a sync RST, every output is 0 next edge: REFRESH, block_sched, debt, refresh_err. The interval counter is 0 and the state is IDLE. RST mid-refresh (any state) aborts to IDLE with no further REFRESH; dram_command is reset on the same line.
- Interval counter:
  - Increments every cycle while init_done=1.
  - At count==TREFI_CYC-1 it wraps to 0 and emits an internal tick (1 cycle).
  - Holds its value while init_done=0.
- Debt update:
  - Each cycle, debt_next = debt + tick - (refresh_ack accepted).
  - Tick and ack in the same cycle leave debt unchanged.
  - A tick at debt==MAX_POSTPONE with no ack: debt stays at MAX_POSTPONE and refresh_err is set, cleared only by RST.
  - An ack at debt==0 cannot occur: it is ignored, and the bench asserts against it.
- States:
  - IDLE:
    - debt>0 & !req_pending & !busy -> ISSUE (opportunistic).
    - debt==MAX_POSTPONE -> FORCE.
    - FORCE takes priority when both conditions hold.
  - FORCE: block_sched=1.
    - Waits for !busy -> ISSUE.
    - An in-flight request completes normally; no new request launches.
  - ISSUE: REFRESH=1, block_sched=1.
    - Stays until refresh_ack; on ack, REFRESH drops next cycle -> TRFC.
  - TRFC: block_sched=1, REFRESH=0.
    - The counter loads TRFC_CYC-1 on entry and decrements.
    - At 0 -> IDLE.
    - Exactly TRFC_CYC cycles are spent in TRFC.
- Latency:
  - REFRESH asserts one cycle after the IDLE/FORCE exit condition is registered.
  - block_sched asserts in the same cycle the state becomes FORCE or ISSUE.
- Priority on return to IDLE: if debt is still >0 and the scheduler is idle, the next refresh starts immediately. Back-to-back REFs are legal after tRFC.
- Debt decrements only on refresh_ack; entering ISSUE does not change debt.
- All outputs are registered; no combinational path from inputs to REFRESH or block_sched.

Decomposition:
- dram_pack gets:
  - refresh_state_t enum {IDLE, FORCE, ISSUE, TRFC};
  - tREFIc and tRFCc localparams, used as the parameter defaults;
  - REF_MAX_POSTPONE = 8.
- One sub-module is natural: refresh_interval_timer (enable, wrap counter, tick out), reusable for the ZQCS interval.
- The FSM and debt counter stay in dram_refresh_ctrl.

Test Plan:
All scenarios use TREFI_CYC=20, TRFC_CYC=5, MAX_POSTPONE=8.
- Reset/init: RST for 2 cycles, init_done=0 for 100 cycles -> debt=0, REFRESH=0, no ticks; then init_done=1 -> first tick 20 cycles later, debt=1.
- Opportunistic: req_pending=0, busy=0; after first tick -> REFRESH=1 next cycle. ack 3 cycles later -> debt=0, REFRESH=0, block_sched=1 for exactly 5 cycles, then IDLE.
- Postpone/force: req_pending=1 continuously -> debt climbs 1..8, no REFRESH. At debt=8 -> block_sched=1. With busy=1 for 10 more cycles REFRESH stays 0; busy falls -> REFRESH next cycle.
- Overflow: debt=8, busy held 1 through the next tick -> refresh_err=1 sticky, debt=8. RST clears both.
- Simultaneous: place refresh_ack in the same cycle as a tick at debt=3 -> debt stays 3, FSM goes to TRFC.
- Reset mid-op: RST asserted while in TRFC with 2 cycles left -> next cycle block_sched=0, REFRESH=0, debt=0, state IDLE.
